commut_adr_seq: RTL
===================

# commut_adr_seq

Parametrised strobe-driven write-address sequencer for the frame commutator buffer. Each synchronised strobe advances a word counter, presents the buffer write address, and generates one timed write-enable pulse inside a fixed-length slot. After `NWORDS` words it flags the frame full, holds a programmable pause, and rewinds. Optionally it ping-pongs between two buffer banks. It sits between the external strobe source and the dual-port frame RAM write port.

## Interface
- `NWORDS`, 20: words per frame; range 2..2^AW.
- `AW`, 5: address width; 2^AW ≥ NWORDS.
- `SLOT`, 64: WRSET slot length in clocks; ≥ 4.
- `WE_ON`, 42: slot count at whose edge WE rises.
- `WE_OFF`, 46: slot count at whose edge WE falls; WE_ON < WE_OFF ≤ SLOT-2.
- `PAUSE_LEN`, 64: clocks spent in PAUSE after the last word; ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `strob` in 1: asynchronous word strobe; level-high request.
- `wrAdr` out AW: write address, equal to word index 0..NWORDS-1; 0 when `adrValid`=0.
- `adrValid` out 1: high while word counter is 1..NWORDS. This replaces tri-stating the address.
- `WE` out 1: RAM write enable, registered.
- `full` out 1: frame complete; registered.
- `wrBank` out 1: bank being written.
- `overrun` out 1: sticky; a strobe rising edge was seen while busy.

## Operation
- Two-flop synchroniser `sync[1:0]` on `strob`, cleared by reset. `sreq`=sync[1]. Rising edge is `sync[1]` with the previous `sync[1]` low, which needs a third flop.
- States:
  - IDLE: on `sreq`, go to CNTWRD and clear `full`.
  - CNTWRD: word counter +1, then go to WRSET.
  - WRSET: slot counter runs 0..SLOT-1.
    - Set WE at edge where count==WE_ON; clear WE at edge where count==WE_OFF.
    - At count==SLOT-1, clear the slot counter.
    - If the word counter == NWORDS: set `full` and go to PAUSE. Otherwise go to WAIT.
  - PAUSE: pause counter runs 0..PAUSE_LEN-1. At PAUSE_LEN-1:
    - Clear the word counter and the pause counter.
    - Toggle `wrBank` (if enabled).
    - Go to WAIT.
  - WAIT: on `sreq`=0, go to IDLE. This gives one word per strobe pulse; a held-high strobe never double-counts.
- `full` stays high from the last slot end until the next accepted strobe (IDLE→CNTWRD).
- `overrun` is set when a synchronised rising edge occurs in CNTWRD, WRSET or PAUSE. That strobe is dropped, not queued. It is cleared only by reset.
- Word counter width is AW+1 bits, so NWORDS=2^AW does not wrap. `wrAdr` = counter-1, truncated to AW bits.
- Illegal state codes recover to IDLE with WE=0.

## Timing
- Reset values: wrAdr=0, adrValid=0, WE=0, full=0, wrBank=0, overrun=0. All counters are 0 and the state is IDLE.
- Strobe latency: `strob` high sampled at edge k, then:
  - k+1: sync[1] high.
  - k+2: IDLE→CNTWRD.
  - k+3: counter incremented; adrValid/wrAdr valid; enter WRSET.
- WE pulse:
  - Rises WE_ON+1 clocks after WRSET entry.
  - High for exactly WE_OFF−WE_ON clocks.
  - `wrAdr` is stable for the whole pulse.
- Slot: WRSET occupies exactly SLOT clocks.
- The last word's address stays valid through PAUSE and drops at PAUSE exit.
- Asynchronous reset mid-slot forces WE low immediately. Nothing is retained; the partial frame is discarded.
- Strobe already low at WRSET exit: WAIT lasts 1 clock, then IDLE.

## Configuration
- `COMMUT_PINGPONG_EN` defined: `wrBank` toggles at every PAUSE exit, so consecutive frames alternate banks. `full` identifies the bank just completed as `~wrBank` after the toggle.
- `COMMUT_PINGPONG_EN` undefined: `wrBank` is tied 0, no toggle logic is synthesised, and all other behaviour is identical.

## Test plan
- Reset, then a single 10-clock strobe (defaults) -> wrAdr=0 and adrValid=1 at k+3. WE high for 4 clocks starting 43 clocks after WRSET entry. Exactly one word; full=0.
- 20 strobe pulses with 80-clock spacing -> wrAdr steps 0..19 with one WE pulse each. full rises at the end of slot 20; adrValid drops 64 clocks later; wrBank toggles iff `COMMUT_PINGPONG_EN` is defined.
- Strobe held high for 300 clocks -> exactly one word written; no further WE until strob falls and rises again.
- Second strobe rising during WRSET -> overrun=1 (sticky), word count unchanged, no extra WE.
- rst low while WE=1 in word 7 -> WE, adrValid and full go to 0 asynchronously. The next strobe writes wrAdr=0.
- Parameters NWORDS=32, AW=5, SLOT=8, WE_ON=2, WE_OFF=5, PAUSE_LEN=1 -> 32 words, addresses 0..31 with no wrap, WE 3 clocks wide per word, full after word 32.

Source files
------------

// File: rtl/commut_adr_seq.sv
// commut_adr_seq: strobe-driven write-address sequencer for the commutator frame RAM.
// Define COMMUT_PINGPONG_EN to alternate wrBank between frames.
module commut_adr_seq #(
  parameter int NWORDS    = 20,
  parameter int AW        = 5,
  parameter int SLOT      = 64,
  parameter int WE_ON     = 42,
  parameter int WE_OFF    = 46,
  parameter int PAUSE_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strob,
  output logic [AW-1:0] wrAdr,
  output logic          adrValid,
  output logic          WE,
  output logic          full,
  output logic          wrBank,
  output logic          overrun
);

  localparam int SW = $clog2(SLOT);
  localparam int PW = $clog2(PAUSE_LEN + 1);

  localparam logic [SW-1:0] S_LAST = SW'(SLOT - 1);
  localparam logic [SW-1:0] S_ON   = SW'(WE_ON);
  localparam logic [SW-1:0] S_OFF  = SW'(WE_OFF);
  localparam logic [PW-1:0] P_LAST = PW'(PAUSE_LEN - 1);
  localparam logic [AW:0]   W_LAST = (AW+1)'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNTWRD = 3'd1,
    S_WRSET  = 3'd2,
    S_PAUSE  = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    sync_q;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          we_q, we_d;
  logic          full_q, full_d;
  logic          ovr_q, ovr_d;
  logic          sreq, rise, busy;
  logic [AW:0]   adr_m1;

  assign sreq = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      pcnt_q  <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], strob};
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      pcnt_q  <= pcnt_d;
      we_q    <= we_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    pcnt_d  = pcnt_q;
    we_d    = we_q;
    full_d  = full_q;
    busy    = (state_q == S_CNTWRD) ||
              (state_q == S_WRSET) ||
              (state_q == S_PAUSE);
    // strobes arriving mid-word are dropped, only flagged
    ovr_d   = ovr_q | (rise & busy);
    unique case (state_q)
      S_IDLE: begin
        if (sreq) begin
          state_d = S_CNTWRD;
          full_d  = 1'b0;
        end
      end
      S_CNTWRD: begin
        wcnt_d  = wcnt_q + (AW+1)'(1);
        state_d = S_WRSET;
      end
      S_WRSET: begin
        scnt_d = scnt_q + SW'(1);
        if (scnt_q == S_ON)  we_d = 1'b1;
        if (scnt_q == S_OFF) we_d = 1'b0;
        if (scnt_q == S_LAST) begin
          scnt_d = '0;
          if (wcnt_q == W_LAST) begin
            full_d  = 1'b1;
            state_d = S_PAUSE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_PAUSE: begin
        pcnt_d = pcnt_q + PW'(1);
        if (pcnt_q == P_LAST) begin
          wcnt_d  = '0;
          pcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!sreq) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

`ifdef COMMUT_PINGPONG_EN
  logic bank_q;
  logic bank_tgl;

  assign bank_tgl = (state_q == S_PAUSE) && (pcnt_q == P_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          bank_q <= 1'b0;
    else if (bank_tgl) bank_q <= ~bank_q;
  end

  assign wrBank = bank_q;
`else
  assign wrBank = 1'b0;
`endif

  assign adr_m1   = wcnt_q - (AW+1)'(1);
  assign adrValid = (wcnt_q != '0);
  assign wrAdr    = adrValid ? adr_m1[AW-1:0] : '0;
  assign WE       = we_q;
  assign full     = full_q;
  assign overrun  = ovr_q;

endmodule
